spi_frame_ctl: RTL and testbench

- Frame-level controller behind spi_slave: consumes its byte stream (byte_rdy/byte_data) plus chip-select and sequences each CS-low frame as a command.
- Opcode byte selects either a config-register write or a burst memory write.
- Memory bursts are packed into 32-bit little-endian words and issued on a valid/ready write port with an auto-incrementing address.
- Sits between spi_slave and the SoC bus/firmware-load path.

---
 rtl/spi_frame_ctl_pkg.sv | 24 ++
 rtl/spi_frame_ctl_if.sv | 39 +++
 rtl/spi_frame_ctl_cs_sync.sv | 36 +++
 rtl/spi_frame_ctl.sv | 179 +++++++++++++++++
 tb/tb_spi_frame_ctl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_pkg
// Brief    : Opcodes and FSM state encoding shared by the SPI frame controller
// Revision : 1.0 - initial release
// ============================================================================
package spi_frame_pkg;

    localparam logic [7:0] OP_WR_CFG = 8'h2A;
    localparam logic [7:0] OP_WR_MEM = 8'h2B;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        OPCODE    = 3'd2,
        CFG       = 3'd3,
        ADDR      = 3'd4,
        DATA      = 3'd5,
        DISCARD   = 3'd6,
        FLUSH     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_frame_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_ctl_if
// Brief    : Byte-stream input, memory write port and config port bundle
// Revision : 1.0 - initial release
// ============================================================================
interface spi_frame_ctl_if #(
    parameter int ADDR_BYTES = 2
);
    localparam int AW = 8 * ADDR_BYTES;

    logic          spi_cs_n_i;
    logic          byte_rdy_i;
    logic [7:0]    byte_data_i;
    logic          mem_wr_valid_o;
    logic          mem_wr_ready_i;
    logic [AW-1:0] mem_wr_addr_o;
    logic [31:0]   mem_wr_data_o;
    logic [3:0]    mem_wr_byteen_o;
    logic          cfg_wr_o;
    logic [7:0]    cfg_data_o;
    logic          busy_o;
    logic          err_overrun_o;

    // Controller side
    modport slave (
        input  spi_cs_n_i, byte_rdy_i, byte_data_i, mem_wr_ready_i,
        output mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o, mem_wr_byteen_o,
        output cfg_wr_o, cfg_data_o, busy_o, err_overrun_o
    );

    // Byte source / memory sink side
    modport master (
        output spi_cs_n_i, byte_rdy_i, byte_data_i, mem_wr_ready_i,
        input  mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o, mem_wr_byteen_o,
        input  cfg_wr_o, cfg_data_o, busy_o, err_overrun_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_ctl_cs_sync.sv
`default_nettype none
// ============================================================================
// Module   : cs_sync
// Brief    : 2-flop chip-select synchronizer with rise/fall pulses, idles high
// Revision : 1.0 - initial release
// ============================================================================
module cs_sync (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic cs_n_i,
    output logic      cs_o,
    output logic      rise_o,
    output logic      fall_o
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronize CS and keep one cycle of history for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= cs_n_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign cs_o   = r_sync2;
    assign rise_o = r_sync2 & ~r_prev;
    assign fall_o = ~r_sync2 & r_prev;
endmodule
`default_nettype wire

// File: rtl/spi_frame_ctl.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_ctl
// Brief    : Sequences CS-low SPI frames into config writes or burst memory
//            writes packed as little-endian 32-bit words
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_ctl
    import spi_frame_pkg::*;
#(
    parameter int ADDR_BYTES = 2
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    spi_frame_ctl_if.slave  bus
);
    localparam int AW = 8 * ADDR_BYTES;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_addr_cnt;
    logic [1:0]    r_lane;
    logic [23:0]   r_buf;
    logic          r_fall_pend;
    logic          r_valid;
    logic [AW-1:0] r_out_addr;
    logic [31:0]   r_out_data;
    logic [3:0]    r_out_be;
    logic          r_cfg_wr;
    logic [7:0]    r_cfg_data;
    logic          r_err;

    logic          w_cs_sync;
    logic          w_cs_rise;
    logic          w_cs_fall;
    logic          w_byte;
    logic          w_out_free;
    logic          w_data_byte;
    logic [1:0]    w_lane_next;
    logic          w_word_done;
    logic          w_load_full;
    logic          w_load_part;
    logic          w_overrun;
    logic          w_addr_last;
    logic          w_fall_pend;
    logic [AW+7:0] w_addr_cat;

    cs_sync u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cs_n_i (bus.spi_cs_n_i),
        .cs_o   (w_cs_sync),
        .rise_o (w_cs_rise),
        .fall_o (w_cs_fall)
    );

    assign w_byte      = bus.byte_rdy_i;
    // Output register can take a new word if empty or draining this cycle
    assign w_out_free  = ~r_valid | bus.mem_wr_ready_i;
    assign w_data_byte = (r_state == DATA) && w_byte;
    assign w_lane_next = w_data_byte ? r_lane + 2'd1 : r_lane;
    assign w_word_done = w_data_byte && (r_lane == 2'd3);
    assign w_load_full = w_word_done && w_out_free;
    assign w_overrun   = w_word_done && !w_out_free;
    assign w_load_part = (r_state == FLUSH) && w_out_free;
    assign w_addr_last = (r_state == ADDR) && w_byte && (r_addr_cnt == 8'(ADDR_BYTES - 1));
    assign w_fall_pend = r_fall_pend | w_cs_fall;
    assign w_addr_cat  = {r_addr, bus.byte_data_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= WAIT_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: byte handling first, then end-of-frame overrides it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_IDLE: if (w_cs_sync) w_state_next = IDLE;
            IDLE:      if (w_cs_fall) w_state_next = OPCODE;
            OPCODE: begin
                if (w_byte) begin
                    if (bus.byte_data_i == OP_WR_CFG)      w_state_next = CFG;
                    else if (bus.byte_data_i == OP_WR_MEM) w_state_next = ADDR;
                    else                                   w_state_next = DISCARD;
                end
            end
            CFG:     if (w_byte) w_state_next = DISCARD;
            ADDR:    if (w_addr_last) w_state_next = DATA;
            FLUSH:   if (w_out_free) w_state_next = w_fall_pend ? OPCODE : IDLE;
            default: w_state_next = r_state;
        endcase
        // FLUSH is only entered with CS high, so a rise there is ignored
        if (w_cs_rise && (r_state != IDLE) && (r_state != WAIT_IDLE) && (r_state != FLUSH)) begin
            if ((r_state == DATA) && (w_lane_next != 2'd0)) w_state_next = FLUSH;
            else                                            w_state_next = IDLE;
        end
    end

    // Address shift/increment, lane counter, word buffer and latched cs_fall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_addr_cnt  <= '0;
            r_lane      <= '0;
            r_buf       <= '0;
            r_fall_pend <= 1'b0;
        end else begin
            if ((r_state == OPCODE) && w_byte) r_addr_cnt <= '0;
            if ((r_state == ADDR) && w_byte) begin
                r_addr_cnt <= r_addr_cnt + 8'd1;
                r_addr     <= w_addr_last ? {w_addr_cat[AW-1:2], 2'b00} : w_addr_cat[AW-1:0];
            end
            if (w_addr_last) begin
                r_lane <= '0;
                r_buf  <= '0;
            end
            if (w_data_byte) begin
                r_lane <= w_lane_next;
                case (r_lane)
                    2'd0:    r_buf[7:0]   <= bus.byte_data_i;
                    2'd1:    r_buf[15:8]  <= bus.byte_data_i;
                    2'd2:    r_buf[23:16] <= bus.byte_data_i;
                    default: r_buf        <= '0;
                endcase
            end
            // Dropped (overrun) words leave the address where it was
            if (w_load_full) r_addr <= r_addr + AW'(4);
            r_fall_pend <= (r_state == FLUSH) && !w_load_part && w_fall_pend;
        end
    end

    // Write port output register with valid/ready handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_be   <= '0;
        end else if (w_load_full) begin
            r_valid    <= 1'b1;
            r_out_addr <= r_addr;
            r_out_data <= {bus.byte_data_i, r_buf};
            r_out_be   <= 4'hF;
        end else if (w_load_part) begin
            r_valid    <= 1'b1;
            r_out_addr <= r_addr;
            r_out_data <= {8'h00, r_buf};
            r_out_be   <= (4'b0001 << r_lane) - 4'b0001;
        end else if (bus.mem_wr_ready_i) begin
            r_valid    <= 1'b0;
        end
    end

    // Config strobe/value and sticky overrun flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg_wr   <= 1'b0;
            r_cfg_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_cfg_wr <= (r_state == CFG) && w_byte;
            if ((r_state == CFG) && w_byte) r_cfg_data <= bus.byte_data_i;
            if (w_overrun) r_err <= 1'b1;
        end
    end

    assign bus.mem_wr_valid_o  = r_valid;
    assign bus.mem_wr_addr_o   = r_out_addr;
    assign bus.mem_wr_data_o   = r_out_data;
    assign bus.mem_wr_byteen_o = r_out_be;
    assign bus.cfg_wr_o        = r_cfg_wr;
    assign bus.cfg_data_o      = r_cfg_data;
    assign bus.err_overrun_o   = r_err;
    assign bus.busy_o          = ((r_state != IDLE) && (r_state != WAIT_IDLE)) || r_valid;
endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_ctl
// Brief    : Scoreboard bench for spi_frame_ctl: directed frames, queued
//            expected writes/config strobes, independent monitor
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_ctl;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // {addr[15:0], data[31:0], byteen[3:0]}
    logic [51:0] exp_wr[$];
    logic [7:0]  exp_cfg[$];

    spi_frame_ctl_if #(.ADDR_BYTES(2)) bus ();

    spi_frame_ctl #(.ADDR_BYTES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        bus.byte_rdy_i  = 1'b1;
        bus.byte_data_i = b;
        @(posedge clk); #2;
        bus.byte_rdy_i  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic set_cs(input logic v);
        @(posedge clk); #2;
        bus.spi_cs_n_i = v;
        repeat (6) @(posedge clk);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_wr.push_back({a, d, be});
    endtask

    // Monitor: compare every accepted write and every config strobe
    initial begin
        logic [51:0] e;
        logic [7:0]  c;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_wr_valid_o && bus.mem_wr_ready_i) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr: got %h/%h/%h expected none",
                             bus.mem_wr_addr_o, bus.mem_wr_data_o, bus.mem_wr_byteen_o);
                end else begin
                    e = exp_wr.pop_front();
                    check("mem_wr", {12'h0, bus.mem_wr_addr_o, bus.mem_wr_data_o, bus.mem_wr_byteen_o},
                          {12'h0, e});
                end
            end
            if (!rst && bus.cfg_wr_o) begin
                if (exp_cfg.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cfg: got %h expected none", bus.cfg_data_o);
                end else begin
                    c = exp_cfg.pop_front();
                    check("cfg_wr", 64'(bus.cfg_data_o), 64'(c));
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_cfg.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp_wr.size() + exp_cfg.size()), 64'd0);
    endtask

    initial begin
        bus.spi_cs_n_i     = 1'b1;
        bus.byte_rdy_i     = 1'b0;
        bus.byte_data_i    = 8'h00;
        bus.mem_wr_ready_i = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.mem_wr_valid_o), 64'd0);
        check("rst_cfg_wr", 64'(bus.cfg_wr_o), 64'd0);
        check("rst_cfg_data", 64'(bus.cfg_data_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_err", 64'(bus.err_overrun_o), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Config write
        exp_cfg.push_back(8'h5C);
        set_cs(1'b0);
        send_byte(8'h2A); send_byte(8'h5C);
        set_cs(1'b1);
        drain("cfg_drain");
        @(negedge clk);
        check("cfg_hold", 64'(bus.cfg_data_o), 64'h5C);
        check("cfg_busy_idle", 64'(bus.busy_o), 64'd0);

        // Two full words
        push_wr(16'h0100, 32'h44332211, 4'hF);
        push_wr(16'h0104, 32'h88776655, 4'hF);
        set_cs(1'b0);
        send_byte(8'h2B); send_byte(8'h01); send_byte(8'h02);
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i));
        set_cs(1'b1);
        drain("burst_drain");

        // Address wrap
        push_wr(16'hFFFC, 32'h04030201, 4'hF);
        push_wr(16'h0000, 32'h08070605, 4'hF);
        set_cs(1'b0);
        send_byte(8'h2B); send_byte(8'hFF); send_byte(8'hFC);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        set_cs(1'b1);
        drain("wrap_drain");

        // Partial word flush
        push_wr(16'h0010, 32'h0000BBAA, 4'b0011);
        set_cs(1'b0);
        send_byte(8'h2B); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAA); send_byte(8'hBB);
        set_cs(1'b1);
        drain("flush_drain");
        @(negedge clk);
        check("flush_busy_idle", 64'(bus.busy_o), 64'd0);

        // Overrun with ready held low
        @(posedge clk); #2;
        bus.mem_wr_ready_i = 1'b0;
        push_wr(16'h0200, 32'h04030201, 4'hF);
        set_cs(1'b0);
        send_byte(8'h2B); send_byte(8'h02); send_byte(8'h00);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        set_cs(1'b1);
        @(negedge clk);
        check("ovr_err", 64'(bus.err_overrun_o), 64'd1);
        check("ovr_valid_held", 64'(bus.mem_wr_valid_o), 64'd1);
        check("ovr_busy", 64'(bus.busy_o), 64'd1);
        @(posedge clk); #2;
        bus.mem_wr_ready_i = 1'b1;
        drain("ovr_drain");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 64'(bus.mem_wr_valid_o), 64'd0);

        // Unknown opcode, then reset mid-frame, then clean config frame
        set_cs(1'b0);
        send_byte(8'h7E); send_byte(8'h2A); send_byte(8'h33);
        set_cs(1'b1);
        set_cs(1'b0);
        send_byte(8'h2B); send_byte(8'h01);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) @(posedge clk); #2;
        rst = 1'b0;
        send_byte(8'h02);
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h11 * i));
        send_byte(8'h2A); send_byte(8'h99);
        @(negedge clk);
        check("rstmid_err_clr", 64'(bus.err_overrun_o), 64'd0);
        check("rstmid_cfg_data", 64'(bus.cfg_data_o), 64'd0);
        set_cs(1'b1);
        exp_cfg.push_back(8'h01);
        set_cs(1'b0);
        send_byte(8'h2A); send_byte(8'h01);
        set_cs(1'b1);
        drain("final_drain");
        @(negedge clk);
        check("final_cfg", 64'(bus.cfg_data_o), 64'h01);
        check("final_busy", 64'(bus.busy_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
